// File: rtl/gpu_pkg.sv
// Shared opcode constants and FSM state encoding for the GPU instruction dispatcher.
package gpu_pkg;

   localparam logic [3:0] OP_WBR = 4'd0;
   localparam logic [3:0] OP_WSM = 4'd1;
   localparam logic [3:0] OP_WBM = 4'd2;
   localparam logic [3:0] OP_DP  = 4'd3;

   localparam int NUM_UNITS = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_A,
      ST_WAIT_A,
      ST_FETCH_B,
      ST_WAIT_B,
      ST_ISSUE,
      ST_DROP
   } state_e;

endpackage

// File: rtl/gpu_opcode_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode onto a legal flag and a one-hot execution unit.
module gpu_opcode_decode
   import gpu_pkg::*;
(
   input  logic [3:0]           opcode_i,
   output logic                 legal_o,
   output logic [NUM_UNITS-1:0] target_o
);

   always_comb begin
      legal_o  = 1'b1;
      target_o = '0;
      case (opcode_i)
         OP_WBR:  target_o = 4'b0001;
         OP_WSM:  target_o = 4'b0010;
         OP_WBM:  target_o = 4'b0100;
         OP_DP:   target_o = 4'b1000;
         default: legal_o  = 1'b0;
      endcase
   end

endmodule

// File: rtl/gpu_instr_dispatcher.sv
// Pops two-word instructions from the instruction FIFO, decodes them and hands each one
// to its execution unit over a valid/ready handshake; illegal opcodes are counted and dropped.
module gpu_instr_dispatcher
   import gpu_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [31:0]          fifo_q,
   input  logic                 fifo_rdempty,
   output logic                 fifo_rdreq,
   output logic [3:0]           cmd_opcode,
   output logic [27:0]          cmd_operand,
   output logic [31:0]          cmd_data,
   output logic [NUM_UNITS-1:0] cmd_valid,
   input  logic [NUM_UNITS-1:0] cmd_ready,
   output logic                 busy,
   output logic [CNT_W-1:0]     instr_count,
   output logic [CNT_W-1:0]     err_count
);

   localparam int              LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

   state_e                 state_q;
   logic [LAT_W-1:0]       lat_q;
   logic [3:0]             opcode_q;
   logic [27:0]            operand_q;
   logic [31:0]            data_q;
   logic [NUM_UNITS-1:0]   valid_q;
   logic [CNT_W-1:0]       instr_q;
   logic [CNT_W-1:0]       err_q;

   logic                   legal;
   logic [NUM_UNITS-1:0]   target;

   gpu_opcode_decode u_decode (
      .opcode_i (opcode_q),
      .legal_o  (legal),
      .target_o (target)
   );

   // The request is gated by the empty flag so a pop is never issued against an empty FIFO;
   // either fetch state simply stalls until data is present.
   assign fifo_rdreq = ((state_q == ST_FETCH_A) || (state_q == ST_FETCH_B)) && !fifo_rdempty;
   assign busy       = (state_q != ST_IDLE);

   assign cmd_opcode  = opcode_q;
   assign cmd_operand = operand_q;
   assign cmd_data    = data_q;
   assign cmd_valid   = valid_q;
   assign instr_count = instr_q;
   assign err_count   = err_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         lat_q     <= '0;
         opcode_q  <= '0;
         operand_q <= '0;
         data_q    <= '0;
         valid_q   <= '0;
         instr_q   <= '0;
         err_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable && !fifo_rdempty) begin
                  state_q <= ST_FETCH_A;
               end
            end
            ST_FETCH_A: begin
               if (!fifo_rdempty) begin
                  lat_q   <= '0;
                  state_q <= ST_WAIT_A;
               end
            end
            ST_WAIT_A: begin
               if (lat_q == LAT_LAST) begin
                  opcode_q  <= fifo_q[3:0];
                  operand_q <= fifo_q[31:4];
                  state_q   <= ST_FETCH_B;
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            ST_FETCH_B: begin
               if (!fifo_rdempty) begin
                  lat_q   <= '0;
                  state_q <= ST_WAIT_B;
               end
            end
            // Word B is always consumed, even for an illegal opcode, so the A/B pairing
            // of the following instructions stays aligned.
            ST_WAIT_B: begin
               if (lat_q == LAT_LAST) begin
                  data_q <= fifo_q;
                  if (legal) begin
                     valid_q <= target;
                     state_q <= ST_ISSUE;
                  end else begin
                     state_q <= ST_DROP;
                  end
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            ST_ISSUE: begin
               if (|(valid_q & cmd_ready)) begin
                  valid_q <= '0;
                  instr_q <= instr_q + 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            ST_DROP: begin
               err_q   <= err_q + 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               valid_q <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_instr_dispatcher.sv
// Scoreboard bench for gpu_instr_dispatcher with a behavioural show-ahead-free FIFO model (1-cycle read latency).
module tb_gpu_instr_dispatcher;
   import gpu_pkg::*;

   localparam int CNT_W = 16;

   typedef struct packed {
      logic [3:0]  valid;
      logic [3:0]  opcode;
      logic [27:0] operand;
      logic [31:0] data;
   } expect_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             enable;
   logic [31:0]      fifo_q = '0;
   logic             fifo_rdempty;
   logic             fifo_rdreq;
   logic [3:0]       cmd_opcode;
   logic [27:0]      cmd_operand;
   logic [31:0]      cmd_data;
   logic [3:0]       cmd_valid;
   logic [3:0]       cmd_ready;
   logic             busy;
   logic [CNT_W-1:0] instr_count;
   logic [CNT_W-1:0] err_count;

   expect_t     sbQ[$];
   logic [31:0] fifoMem [0:63];
   int          wrPtr    = 0;
   int          rdPtr    = 0;
   int          dropCnt  = 0;
   int          checks   = 0;
   int          failures = 0;
   int          rdCount  = 0;
   int          expInstr = 0;
   int          expErr   = 0;

   gpu_instr_dispatcher #(.RD_LATENCY(1), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .fifo_q       (fifo_q),
      .fifo_rdempty (fifo_rdempty),
      .fifo_rdreq   (fifo_rdreq),
      .cmd_opcode   (cmd_opcode),
      .cmd_operand  (cmd_operand),
      .cmd_data     (cmd_data),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .busy         (busy),
      .instr_count  (instr_count),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   // FIFO model: dropCnt lets the stimulus side flush the FIFO without touching the read pointer.
   assign fifo_rdempty = (wrPtr == rdPtr + dropCnt);

   always @(posedge clk) begin
      if (fifo_rdreq && !fifo_rdempty) begin
         fifo_q <= fifoMem[(rdPtr + dropCnt) & 63];
         rdPtr  <= rdPtr + 1;
      end
   end

   function automatic int fifoLevel();
      return wrPtr - rdPtr - dropCnt;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic pushWord(input logic [31:0] w);
      fifoMem[wrPtr & 63] = w;
      wrPtr++;
   endtask

   task automatic expectInstr(input logic [31:0] a, input logic [31:0] b);
      logic [3:0] op;
      expect_t    e;
      op = a[3:0];
      if (op < 4'd4) begin
         e.valid   = 4'b0001 << op;
         e.opcode  = op;
         e.operand = a[31:4];
         e.data    = b;
         sbQ.push_back(e);
      end else begin
         expErr++;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      pushWord(a);
      pushWord(b);
      expectInstr(a, b);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitIdle(input string tag, input int maxCycles);
      bit done;
      done = 1'b0;
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clk);
         if (!busy && fifoLevel() == 0 && sbQ.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) checkOutput(tag, 64'd1, 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] rdreqExp;
      bit         seen;
      int         rd0;

      reset_n   = 1'b0;
      enable    = 1'b1;
      cmd_ready = 4'b1111;

      // Monitor: protocol check on every pop and scoreboard compare on every completed handshake.
      fork
         begin : monitor
            expect_t e;
            forever begin
               @(negedge clk);
               if (reset_n) begin
                  if (fifo_rdreq) begin
                     rdCount++;
                     checkOutput("rdreq_while_empty", 64'(fifo_rdempty), 64'd0);
                  end
                  if ((cmd_valid & cmd_ready) != 4'b0000) begin
                     if (sbQ.size() == 0) begin
                        checkOutput("unexpected_issue", 64'(cmd_valid), 64'd0);
                     end else begin
                        e = sbQ.pop_front();
                        checkOutput("issue_valid",   64'(cmd_valid),   64'(e.valid));
                        checkOutput("issue_opcode",  64'(cmd_opcode),  64'(e.opcode));
                        checkOutput("issue_operand", 64'(cmd_operand), 64'(e.operand));
                        checkOutput("issue_data",    64'(cmd_data),    64'(e.data));
                        expInstr++;
                     end
                  end
               end
            end
         end
      join_none

      // Reset held with a non-empty FIFO
      pushWord(32'h0000_0013);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_rdreq",  64'(fifo_rdreq),  64'd0);
      checkOutput("reset_valid",  64'(cmd_valid),   64'd0);
      checkOutput("reset_instr",  64'(instr_count), 64'd0);
      checkOutput("reset_err",    64'(err_count),   64'd0);
      checkOutput("reset_busy",   64'(busy),        64'd0);
      checkOutput("reset_data",   64'(cmd_data),    64'd0);
      dropCnt = wrPtr - rdPtr;
      reset_n = 1'b1;
      waitCycles(2);

      // Basic WSM instruction, cycle-exact pop and issue timing
      applyStimulus(32'h0000_0011, 32'hDEAD_BEEF);
      rdreqExp = 7'b0001010;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t2_rdreq_c%0d", k), 64'(fifo_rdreq), 64'(rdreqExp[k]));
         checkOutput($sformatf("t2_valid_c%0d", k), 64'(cmd_valid), (k == 5) ? 64'h2 : 64'h0);
      end
      checkOutput("t2_instr_count", 64'(instr_count), 64'(expInstr));
      checkOutput("t2_instr_one",   64'(instr_count), 64'd1);
      @(posedge clk);
      #1;

      // DP held off by its unit for 10 cycles; other ready bits high must not complete it
      cmd_ready = 4'b0111;
      applyStimulus(32'h00AB_CDE3, 32'h1234_5678);
      applyStimulus(32'h0000_0070, 32'h0F0F_0F0F);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_valid != 4'b0000) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("t3_valid_seen", 64'(seen), 64'd1);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         checkOutput("t3_hold_valid",   64'(cmd_valid),   64'h8);
         checkOutput("t3_hold_operand", 64'(cmd_operand), 64'h00A_BCDE);
         checkOutput("t3_hold_data",    64'(cmd_data),    64'h1234_5678);
         checkOutput("t3_hold_rdreq",   64'(fifo_rdreq),  64'd0);
      end
      @(posedge clk);
      #1;
      cmd_ready = 4'b1111;
      waitIdle("t3_timeout", 40);
      checkOutput("t3_instr_count", 64'(instr_count), 64'(expInstr));

      // Word B arrives late: stall in the second fetch without popping
      pushWord(32'h0000_0452);
      expectInstr(32'h0000_0452, 32'h0BAD_CAFE);
      waitCycles(3);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("t4_stall_rdreq", 64'(fifo_rdreq), 64'd0);
         checkOutput("t4_stall_busy",  64'(busy),       64'd1);
      end
      @(posedge clk);
      #1;
      pushWord(32'h0BAD_CAFE);
      waitIdle("t4_timeout", 30);
      checkOutput("t4_instr_count", 64'(instr_count), 64'(expInstr));

      // Illegal opcode is dropped with word B consumed, then a legal instruction follows
      applyStimulus(32'h0000_00AF, 32'h5555_5555);
      applyStimulus(32'h0000_0020, 32'hCAFE_F00D);
      waitIdle("t5_timeout", 40);
      checkOutput("t5_err_count",   64'(err_count),   64'(expErr));
      checkOutput("t5_err_one",     64'(err_count),   64'd1);
      checkOutput("t5_instr_count", 64'(instr_count), 64'(expInstr));
      checkOutput("t5_fifo_level",  64'(fifoLevel()), 64'd0);

      // enable low blocks fetching; dropping it mid-instruction lets that one finish
      enable = 1'b0;
      applyStimulus(32'h0000_0100, 32'hAAAA_0001);
      applyStimulus(32'h0000_0201, 32'hAAAA_0002);
      applyStimulus(32'h0000_0303, 32'hAAAA_0003);
      rd0 = rdCount;
      waitCycles(10);
      checkOutput("t6_no_fetch_rdcount", 64'(rdCount),     64'(rd0));
      checkOutput("t6_no_fetch_level",   64'(fifoLevel()), 64'd6);
      checkOutput("t6_no_fetch_busy",    64'(busy),        64'd0);
      enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (fifo_rdreq) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("t6_fetch_start", 64'(seen), 64'd1);
      waitCycles(1);
      waitCycles(1);
      enable = 1'b0;
      waitCycles(12);
      checkOutput("t6_after_level", 64'(fifoLevel()), 64'd4);
      checkOutput("t6_after_busy",  64'(busy),        64'd0);
      checkOutput("t6_after_instr", 64'(instr_count), 64'(expInstr));
      checkOutput("t6_after_rd",    64'(rdCount),     64'(rd0 + 2));

      // Reset asserted while waiting for word B
      enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (fifo_rdreq) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("t6_refetch_start", 64'(seen), 64'd1);
      waitCycles(1);
      waitCycles(1);
      waitCycles(1);
      reset_n = 1'b0;
      waitCycles(1);
      checkOutput("t6_rst_busy",    64'(busy),        64'd0);
      checkOutput("t6_rst_valid",   64'(cmd_valid),   64'd0);
      checkOutput("t6_rst_rdreq",   64'(fifo_rdreq),  64'd0);
      checkOutput("t6_rst_instr",   64'(instr_count), 64'd0);
      checkOutput("t6_rst_err",     64'(err_count),   64'd0);
      checkOutput("t6_rst_opcode",  64'(cmd_opcode),  64'd0);
      checkOutput("t6_rst_operand", 64'(cmd_operand), 64'd0);
      checkOutput("t6_rst_data",    64'(cmd_data),    64'd0);
      dropCnt = wrPtr - rdPtr;
      sbQ.delete();
      expInstr = 0;
      expErr   = 0;
      reset_n  = 1'b1;
      waitCycles(2);

      applyStimulus(32'h0000_0101, 32'h600D_F00D);
      waitIdle("t6_recover_timeout", 30);
      checkOutput("t6_recover_instr", 64'(instr_count), 64'd1);
      checkOutput("t6_recover_err",   64'(err_count),   64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
